// File: rtl/fp_norm_pkg.sv
// Shared types and constants for the single-precision post-add normalizer.
package fp_norm_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;

  localparam logic [EXP_W-1:0] EXP_MAX      = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_MIN_NORM = {{(EXP_W-1){1'b0}}, 1'b1};

  // IDLE : waiting for an operand
  // NORM : shifting mantissa / adjusting exponent
  // DONE : result presented, waiting for out_ready
  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  typedef logic [EXP_W-1:0]  exp_t;
  typedef logic [MANT_W+1:0] mant_t;

endpackage

// File: rtl/fp_exp_step.sv
// Exponent step unit: res = a + step or a - step through a ripple full-adder
// chain. co is the carry-out when adding and the borrow-out when subtracting.
module fp_exp_step #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] step,
  input  logic         sub,
  output logic [W-1:0] res,
  output logic         co
);

  logic [W:0]   c;
  logic [W-1:0] b;

  assign b    = step ^ {W{sub}};
  assign c[0] = sub;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign res[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  // Subtraction via two's complement: borrow is the inverted carry.
  assign co = sub ? ~c[W] : c[W];

endmodule

// File: rtl/fp_norm_seq.sv
// Sequential normalizer for the single-precision add/sub datapath.
// Optional build macro FP_NORM_FAST_LZC_EN: whole left shift in one NORM cycle
// using a leading-zero count; results are bit-identical to the iterative mode.
module fp_norm_seq
  import fp_norm_pkg::*;
#(
  parameter int EXP_W  = fp_norm_pkg::EXP_W,
  parameter int MANT_W = fp_norm_pkg::MANT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W+1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W-1:0] out_mant,
  output logic              out_ovf,
  output logic              out_unf,
  output logic              out_zero
);

  localparam logic [EXP_W-1:0] EMAX = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EONE = {{(EXP_W-1){1'b0}}, 1'b1};

  state_t state, state_nxt;

  logic              sign_r;
  logic [EXP_W-1:0]  exp_r;
  logic [MANT_W+1:0] mant_r;

  logic [EXP_W-1:0]  step_amt;
  logic              step_sub;
  logic [EXP_W-1:0]  step_res;
  logic              step_co;

  logic [EXP_W-1:0]  nxt_exp;
  logic [MANT_W+1:0] nxt_mant;
  logic              fin;
  logic              f_ovf, f_unf, f_zero;

  fp_exp_step #(.W(EXP_W)) u_step (
    .a    (exp_r),
    .step (step_amt),
    .sub  (step_sub),
    .res  (step_res),
    .co   (step_co)
  );

`ifdef FP_NORM_FAST_LZC_EN
  logic [EXP_W-1:0] lz;

  // Leading zeros above the hidden bit; only meaningful for a nonzero mantissa.
  always_comb begin
    lz = '0;
    for (int i = 0; i <= MANT_W; i++) begin
      if (mant_r[i]) lz = EXP_W'(MANT_W - i);
    end
  end
`endif

  // Step unit operands: +1 on carry, otherwise a decrement by the shift amount.
  always_comb begin
    step_sub = ~mant_r[MANT_W+1];
    step_amt = EONE;
`ifdef FP_NORM_FAST_LZC_EN
    if (!mant_r[MANT_W+1]) begin
      if (lz < exp_r) step_amt = lz;
      else            step_amt = exp_r - 1'b1;
    end
`endif
  end

  // One normalization step, rules checked in priority order.
  always_comb begin
    nxt_exp  = exp_r;
    nxt_mant = mant_r;
    fin      = 1'b0;
    f_ovf    = 1'b0;
    f_unf    = 1'b0;
    f_zero   = 1'b0;
    if (exp_r == EMAX) begin
      fin = 1'b1;
    end else if (mant_r == '0) begin
      nxt_exp  = '0;
      nxt_mant = '0;
      f_zero   = 1'b1;
      fin      = 1'b1;
    end else if (mant_r[MANT_W+1]) begin
      nxt_mant = mant_r >> 1;
      nxt_exp  = step_res;
      fin      = 1'b1;
      if (step_res == EMAX || step_co) begin
        nxt_exp  = EMAX;
        nxt_mant = '0;
        f_ovf    = 1'b1;
      end
    end else if (mant_r[MANT_W]) begin
      fin = 1'b1;
    end else if (exp_r == '0) begin
      fin = 1'b1;
    end else if (exp_r == EONE) begin
      nxt_exp = '0;
      f_unf   = 1'b1;
      fin     = 1'b1;
    end else begin
`ifdef FP_NORM_FAST_LZC_EN
      // Shift clamped at exp-1 lands on exp==1 with hidden=0: denormal result.
      fin      = 1'b1;
      nxt_mant = mant_r << step_amt;
      if (lz < exp_r) begin
        nxt_exp = step_res;
      end else begin
        nxt_exp = '0;
        f_unf   = 1'b1;
      end
`else
      nxt_mant = mant_r << 1;
      nxt_exp  = step_res;
`endif
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)              state_nxt = NORM;
      NORM:    if (fin)                   state_nxt = DONE;
      DONE:    if (out_valid && out_ready) state_nxt = IDLE;
      default:                            state_nxt = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    in_ready = (state == IDLE);
  end

  // Working registers and registered result; out_valid rises one edge after DONE entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_r    <= 1'b0;
      exp_r     <= '0;
      mant_r    <= '0;
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
      out_exp   <= '0;
      out_mant  <= '0;
      out_ovf   <= 1'b0;
      out_unf   <= 1'b0;
      out_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_r <= in_sign;
            exp_r  <= in_exp;
            mant_r <= in_mant;
          end
        end
        NORM: begin
          exp_r  <= nxt_exp;
          mant_r <= nxt_mant;
          if (fin) begin
            out_sign <= sign_r;
            out_exp  <= nxt_exp;
            out_mant <= nxt_mant[MANT_W-1:0];
            out_ovf  <= f_ovf;
            out_unf  <= f_unf;
            out_zero <= f_zero;
          end
        end
        DONE: begin
          if (!out_valid)     out_valid <= 1'b1;
          else if (out_ready) out_valid <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: doc/fp_norm_seq.md
Name: fp_norm_seq

Overview:
- Sequential post-operation normalizer for the single-precision floating-point datapath.
- Consumes the raw sign, exponent and mantissa sum from the aligned-mantissa adder/subtractor. Produces an IEEE-754 normalized (or denormal/special) result.
- This is the reverse direction of exponent-difference alignment: it shifts the mantissa back into place and re-adjusts the exponent, one step per clock.
- Valid/ready handshake on both sides.

Parameters:
- EXP_W, 8, exponent width
- MANT_W, 23, stored fraction width (hidden bit excluded)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input operand valid
- in_ready  output  1  block can accept an operand
- in_sign  input  1  result sign
- in_exp  input  EXP_W  biased exponent before normalization
- in_mant  input  MANT_W+2  raw sum; bit MANT_W+1 = carry, bit MANT_W = hidden bit
- out_valid  output  1  normalized result valid
- out_ready  input  1  downstream accepts the result
- out_sign  output  1  result sign
- out_exp  output  EXP_W  normalized biased exponent
- out_mant  output  MANT_W  fraction, hidden bit dropped
- out_ovf  output  1  exponent overflowed to infinity
- out_unf  output  1  result became denormal (exponent reached minimum)
- out_zero  output  1  mantissa was zero

Behaviour:
- Reset:
  - Async, active-low; all outputs and state clear immediately.
  - Values: in_ready=1, out_valid=0, every data and flag output 0, state IDLE.
- States: IDLE, NORM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register sign/exp/mant and go to NORM.
- NORM, priority order:
  - Exp all-ones (Inf/NaN): pass through unchanged, flags 0 -> DONE.
  - Mant==0: exp=0, mant=0, out_zero=1 -> DONE.
  - Carry bit set: shift right 1, exp+1. If exp becomes all-ones: mant=0, out_ovf=1 -> DONE.
  - Hidden bit set: -> DONE.
  - Exp==0 with hidden=0 (input already denormal): no shift -> DONE.
  - Exp==1 with hidden=0: exp=0, out_unf=1 -> DONE.
  - Otherwise: shift left 1, exp-1, stay in NORM.
- DONE:
  - out_valid=1; outputs hold stable until out_ready.
  - On out_valid&&out_ready: return to IDLE, out_valid=0 next cycle.
- Latency and throughput:
  - in_ready=0 in NORM and DONE; at most one operand in flight.
  - out_valid rises k+2 edges after the accepting edge, where k = number of left shifts (0..MANT_W).
  - No bubble-free throughput is required.
- Exponent arithmetic: done in the step unit; width EXP_W plus carry/borrow-out. Borrow never escapes because of the exp==1 stop.
- Reset mid-NORM or mid-DONE aborts the operation with no output.
- in_valid while busy is ignored.

Optional Feature:
- Macro: FP_NORM_FAST_LZC_EN.
- Defined: NORM uses a leading-zero counter and performs the whole left shift in one cycle. Shift = min(lzc, exp-1); exp reduced accordingly; denormal stop rule unchanged. out_valid is always 2 edges after accept.
- Undefined: iterative one-bit-per-cycle shifting as above.
- Outputs are bit-identical in both modes.

Decomposition:
- Package fp_norm_pkg:
  - Constants EXP_W, MANT_W, EXP_MAX (all-ones), EXP_MIN_NORM (1).
  - State enum typedef {IDLE, NORM, DONE}.
  - Mantissa and exponent width typedefs.
- Sub-module fp_exp_step: EXP_W-bit exponent increment/decrement by a step (1, or lzc under the macro), with carry/borrow out, built from the team's full-adder chain.

Test Plan:
- Already normalized: in_mant=0x0800000, in_exp=0x80 -> out_exp=0x80, out_mant=0, flags 0, out_valid 2 edges after accept.
- Carry: in_mant=0x1000000, in_exp=0x80 -> out_exp=0x81, out_mant=0, latency 2.
- Deep shift: in_mant=0x0000001, in_exp=0x80 -> out_exp=0x69, out_mant=0, latency 25 (2 with FP_NORM_FAST_LZC_EN).
- Underflow: in_mant=0x0000100, in_exp=0x03 -> out_exp=0x00, out_mant=0x000400, out_unf=1.
- Overflow: in_mant=0x1800000, in_exp=0xFE -> out_exp=0xFF, out_mant=0, out_ovf=1.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles: outputs stable, in_ready=0, new in_valid ignored.
  - Assert rst_n=0 mid-NORM: out_valid=0 and in_ready=1 immediately.
